// File: rtl/div_clk_monitor.sv
// Measures the period of an asynchronous divided clock in clk_ext cycles and reports
// lock, mismatch and timeout status against an expected period.
module div_clk_monitor #(
    parameter int unsigned W          = 8,
    parameter int unsigned TOL        = 0,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned MAX_PERIOD = 255
) (
    input  logic         clk_ext,
    input  logic         rst,
    input  logic         en,
    input  logic         clk_div,
    input  logic [W-1:0] exp_period,
    output logic [W-1:0] period,
    output logic         period_valid,
    output logic         locked,
    output logic         err,
    output logic         timeout
);

    localparam logic [W-1:0] MaxP  = W'(MAX_PERIOD);
    localparam logic [W:0]   Tol   = (W+1)'(TOL);
    localparam logic [3:0]   LockN = 4'(LOCK_CNT);

    typedef enum logic [1:0] {StIdle, StArm, StMeasure} state_e;

    state_e       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] period_q, period_d;
    logic [3:0]   mc_q, mc_d;
    logic         locked_q, locked_d;
    logic         pv_q, pv_d;
    logic         err_q, err_d;
    logic         to_q, to_d;
    logic         s1_q, s2_q, s3_q;

    logic         rise;
    logic [W:0]   diff;
    logic         match;

    assign rise = s2_q & ~s3_q;

    // Absolute difference in W+1 bits so the compare never wraps.
    always_comb begin
        if (cnt_q >= exp_period) begin
            diff = {1'b0, cnt_q} - {1'b0, exp_period};
        end else begin
            diff = {1'b0, exp_period} - {1'b0, cnt_q};
        end
        match = (diff <= Tol);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        mc_d     = mc_q;
        locked_d = locked_q;
        pv_d     = 1'b0;
        err_d    = 1'b0;
        to_d     = 1'b0;
        if (!en) begin
            state_d  = StIdle;
            cnt_d    = '0;
            mc_d     = '0;
            locked_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_d   = '0;
                    state_d = StArm;
                end
                StArm: begin
                    if (rise) begin
                        cnt_d   = W'(1);
                        state_d = StMeasure;
                    end else if (cnt_q == MaxP) begin
                        to_d     = 1'b1;
                        locked_d = 1'b0;
                        mc_d     = '0;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + W'(1);
                    end
                end
                StMeasure: begin
                    if (rise) begin
                        period_d = cnt_q;
                        pv_d     = 1'b1;
                        cnt_d    = W'(1);
                        if (match) begin
                            mc_d     = (mc_q >= LockN) ? LockN : mc_q + 4'd1;
                            locked_d = locked_q | (mc_d == LockN);
                        end else begin
                            err_d    = 1'b1;
                            mc_d     = '0;
                            locked_d = 1'b0;
                        end
                    end else if (cnt_q == MaxP) begin
                        to_d     = 1'b1;
                        locked_d = 1'b0;
                        mc_d     = '0;
                        cnt_d    = '0;
                        state_d  = StArm;
                    end else begin
                        cnt_d = cnt_q + W'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_ext) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            period_q <= '0;
            mc_q     <= '0;
            locked_q <= 1'b0;
            pv_q     <= 1'b0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            mc_q     <= mc_d;
            locked_q <= locked_d;
            pv_q     <= pv_d;
            err_q    <= err_d;
            to_q     <= to_d;
            s1_q     <= clk_div;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
        end
    end

    assign period       = period_q;
    assign period_valid = pv_q;
    assign locked       = locked_q;
    assign err          = err_q;
    assign timeout      = to_q;

endmodule
